// File: rtl/spi_slave_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : spi_slave_param
// Brief   : Oversampled SPI slave with tagged write / read-address / read-data frames.
// Revision: 1.0 - initial release
// ============================================================================
module spi_slave_param #(
  parameter int RX_W      = 10,
  parameter int TX_W      = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            SS_n,
  input  logic            MOSI,
  input  logic [TX_W-1:0] tx_data,
  input  logic            tx_valid,
  output logic            MISO,
  output logic [RX_W-1:0] rx_data,
  output logic            rx_valid,
  output logic            busy,
  output logic            frame_err
);

  localparam int RXC_W = $clog2(RX_W + 1);
  localparam int TXC_W = $clog2(TX_W + 1);
  localparam logic [RXC_W-1:0] c_RX_LAST = RXC_W'(RX_W - 1);
  localparam logic [TXC_W-1:0] c_TX_ALL  = TXC_W'(TX_W);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHK_CMD   = 3'd1,
    S_WRITE     = 3'd2,
    S_READ_ADD  = 3'd3,
    S_READ_DATA = 3'd4,
    S_TX        = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [RXC_W-1:0]  r_rx_cnt;
  logic [RX_W-2:0]   r_rx_sr;     // bits received so far; the live MOSI bit completes the frame
  logic [RX_W-1:0]   w_rx_frame;
  logic [RX_W-2:0]   w_rx_sr_nxt;
  logic [TXC_W-1:0]  r_tx_cnt;
  logic [TX_W-1:0]   r_tx_sr;
  logic              r_tx_active;
  logic              r_rd_addr_seen;
  logic              r_miso, r_rx_valid, r_frame_err;
  logic [RX_W-1:0]   r_rx_data;
  logic              w_abort, w_rx_shift, w_rx_done;
  logic              w_tx_capture, w_tx_shift, w_tx_end;
  logic              w_tx_first, w_tx_head;
  logic [TX_W-1:0]   w_tx_rest, w_tx_adv;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_rx_frame  = {MOSI, r_rx_sr};
      assign w_rx_sr_nxt = w_rx_frame[RX_W-1:1];
      assign w_tx_first  = tx_data[0];
      assign w_tx_rest   = tx_data >> 1;
      assign w_tx_head   = r_tx_sr[0];
      assign w_tx_adv    = r_tx_sr >> 1;
    end else begin : g_msb_first
      assign w_rx_frame  = {r_rx_sr, MOSI};
      assign w_rx_sr_nxt = w_rx_frame[RX_W-2:0];
      assign w_tx_first  = tx_data[TX_W-1];
      assign w_tx_rest   = tx_data << 1;
      assign w_tx_head   = r_tx_sr[TX_W-1];
      assign w_tx_adv    = r_tx_sr << 1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_abort      = 1'b0;
    w_rx_shift   = 1'b0;
    w_rx_done    = 1'b0;
    w_tx_capture = 1'b0;
    w_tx_shift   = 1'b0;
    w_tx_end     = 1'b0;
    case (r_state)
      S_IDLE: if (!SS_n) w_state_nxt = S_CHK_CMD;
      S_CHK_CMD: begin
        if (SS_n) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!MOSI)        w_state_nxt = S_WRITE;
        else if (r_rd_addr_seen)   w_state_nxt = S_READ_DATA;
        else                       w_state_nxt = S_READ_ADD;
      end
      S_WRITE, S_READ_ADD, S_READ_DATA: begin
        // Deselect wins over a frame that would complete on the same edge
        if (SS_n) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_rx_shift = 1'b1;
          if (r_rx_cnt == c_RX_LAST) begin
            w_rx_done   = 1'b1;
            w_state_nxt = (r_state == S_READ_DATA) ? S_TX : S_DONE;
          end
        end
      end
      S_TX: begin
        if (SS_n) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!r_tx_active) begin
          w_tx_capture = tx_valid;
        end else if (r_tx_cnt == c_TX_ALL) begin
          w_tx_end    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_tx_shift = 1'b1;
        end
      end
      S_DONE: if (SS_n) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_cnt       <= '0;
      r_rx_sr        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_frame_err    <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_tx_cnt       <= '0;
      r_tx_sr        <= '0;
      r_tx_active    <= 1'b0;
      r_miso         <= 1'b0;
    end else begin
      r_rx_valid  <= w_rx_done;
      r_frame_err <= w_abort;
      if (w_abort) begin
        r_rx_cnt    <= '0;
        r_rx_sr     <= '0;
        r_tx_cnt    <= '0;
        r_tx_sr     <= '0;
        r_tx_active <= 1'b0;
        r_miso      <= 1'b0;
      end else begin
        if (w_rx_done) begin
          r_rx_data <= w_rx_frame;
          r_rx_cnt  <= '0;
          r_rx_sr   <= '0;
          if (r_state == S_READ_ADD)  r_rd_addr_seen <= 1'b1;
          if (r_state == S_READ_DATA) r_rd_addr_seen <= 1'b0;
        end else if (w_rx_shift) begin
          r_rx_sr  <= w_rx_sr_nxt;
          r_rx_cnt <= r_rx_cnt + RXC_W'(1);
        end
        if (w_tx_capture) begin
          r_miso      <= w_tx_first;
          r_tx_sr     <= w_tx_rest;
          r_tx_cnt    <= TXC_W'(1);
          r_tx_active <= 1'b1;
        end else if (w_tx_shift) begin
          r_miso   <= w_tx_head;
          r_tx_sr  <= w_tx_adv;
          r_tx_cnt <= r_tx_cnt + TXC_W'(1);
        end else if (w_tx_end) begin
          r_miso      <= 1'b0;
          r_tx_sr     <= '0;
          r_tx_cnt    <= '0;
          r_tx_active <= 1'b0;
        end
      end
    end
  end

  assign MISO      = r_miso;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_spi_slave_param
// Brief   : Directed self-checking bench for spi_slave_param (MSB and LSB builds).
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_slave_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss = 1'b1, mosi = 1'b0, txv = 1'b0;
  logic [7:0]  txd = 8'h00;
  logic        miso, rxv, busy, ferr;
  logic [9:0]  rxd;
  logic        ss2 = 1'b1, mosi2 = 1'b0, txv2 = 1'b0;
  logic [15:0] txd2 = 16'h0000;
  logic        miso2, rxv2, busy2, ferr2;
  logic [15:0] rxd2;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  spi_slave_param dut (
    .clk(clk), .rst_n(rst_n), .SS_n(ss), .MOSI(mosi), .tx_data(txd), .tx_valid(txv),
    .MISO(miso), .rx_data(rxd), .rx_valid(rxv), .busy(busy), .frame_err(ferr)
  );

  spi_slave_param #(.RX_W(16), .TX_W(16), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .SS_n(ss2), .MOSI(mosi2), .tx_data(txd2), .tx_valid(txv2),
    .MISO(miso2), .rx_data(rxd2), .rx_valid(rxv2), .busy(busy2), .frame_err(ferr2)
  );

  // One rising edge, then settle at the falling edge where inputs change and outputs are read
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_frame(input logic cmd, input logic [9:0] d);
    ss = 1'b0; step();
    mosi = cmd; step();
    for (int i = 9; i >= 0; i--) begin
      mosi = d[i]; step();
    end
  endtask

  task automatic drive_frame_lsb(input logic cmd, input logic [15:0] d);
    ss2 = 1'b0; step();
    mosi2 = cmd; step();
    for (int i = 0; i < 16; i++) begin
      mosi2 = d[i]; step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    n_chk++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", miso); end
    n_chk++; if (rxd !== 10'h000) begin n_fail++; $display("FAIL reset_rxd: got %h want 000", rxd); end
    n_chk++; if (rxv !== 1'b0) begin n_fail++; $display("FAIL reset_rxv: got %b want 0", rxv); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", ferr); end
    n_chk++; if (rxd2 !== 16'h0000) begin n_fail++; $display("FAIL reset_rxd2: got %h want 0000", rxd2); end
    rst_n = 1'b1;
    step();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_write();
    logic [9:0] d;
    logic       miso_bad;
    logic       early;
    d = 10'b00_1010_0101;
    miso_bad = 1'b0;
    early = 1'b0;
    ss = 1'b0; step();                       // edge 1 samples SS_n low
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b want 1", busy); end
    mosi = 1'b0; step();                     // edge 2: command bit
    for (int i = 9; i >= 0; i--) begin       // edges 3..12
      mosi = d[i]; step();
      if (miso !== 1'b0) miso_bad = 1'b1;
      if (i > 0 && rxv !== 1'b0) early = 1'b1;
    end
    n_chk++; if (early) begin n_fail++; $display("FAIL write_early_rxv: got 1 before edge 12 want 0"); end
    n_chk++; if (rxv !== 1'b1) begin n_fail++; $display("FAIL write_rxv: got %b want 1", rxv); end
    n_chk++; if (rxd !== 10'h0A5) begin n_fail++; $display("FAIL write_rxd: got %h want 0a5", rxd); end
    ss = 1'b1; mosi = 1'b0; step();
    n_chk++; if (rxv !== 1'b0) begin n_fail++; $display("FAIL write_rxv_pulse: got %b want 0", rxv); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_idle: got %b want 0", busy); end
    n_chk++; if (miso_bad || miso !== 1'b0) begin n_fail++; $display("FAIL write_miso: got nonzero want 0"); end
    n_chk++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL write_ferr: got %b want 0", ferr); end
  endtask

  task automatic test_read();
    logic [7:0] exp;
    exp = 8'hC5;
    txv = 1'b0;
    drive_frame(1'b1, 10'b10_0000_0011);
    n_chk++; if (rxd !== 10'h203 || rxv !== 1'b1) begin n_fail++; $display("FAIL rdadd_rx: got %h/%b want 203/1", rxd, rxv); end
    ss = 1'b1; step();
    txd = 8'hC5; txv = 1'b1;
    drive_frame(1'b1, 10'b11_0000_0000);
    n_chk++; if (rxd !== 10'h300 || rxv !== 1'b1) begin n_fail++; $display("FAIL rddata_rx: got %h/%b want 300/1", rxd, rxv); end
    n_chk++; if (miso !== 1'b0) begin n_fail++; $display("FAIL rddata_miso_pre: got %b want 0", miso); end
    for (int i = 7; i >= 0; i--) begin
      step();
      n_chk++; if (miso !== exp[i]) begin n_fail++; $display("FAIL read_miso_bit%0d: got %b want %b", i, miso, exp[i]); end
    end
    step();
    n_chk++; if (miso !== 1'b0) begin n_fail++; $display("FAIL read_miso_post: got %b want 0", miso); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL read_done_busy: got %b want 1", busy); end
    ss = 1'b1; txv = 1'b0; step();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_idle: got %b want 0", busy); end
  endtask

  task automatic test_abort();
    ss = 1'b0; step();
    mosi = 1'b0; step();
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1; step();
    end
    ss = 1'b1; step();
    n_chk++; if (ferr !== 1'b1) begin n_fail++; $display("FAIL abort_ferr: got %b want 1", ferr); end
    n_chk++; if (rxv !== 1'b0) begin n_fail++; $display("FAIL abort_rxv: got %b want 0", rxv); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_chk++; if (rxd !== 10'h300) begin n_fail++; $display("FAIL abort_rxd: got %h want 300", rxd); end
    step();
    n_chk++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL abort_ferr_pulse: got %b want 0", ferr); end
    // Deselect on the very edge that would complete the frame
    ss = 1'b0; step();
    mosi = 1'b0; step();
    for (int i = 0; i < 9; i++) begin
      mosi = 1'b1; step();
    end
    ss = 1'b1; step();
    n_chk++; if (ferr !== 1'b1 || rxv !== 1'b0) begin n_fail++; $display("FAIL collide_flags: got ferr=%b rxv=%b want 1/0", ferr, rxv); end
    n_chk++; if (rxd !== 10'h300) begin n_fail++; $display("FAIL collide_rxd: got %h want 300", rxd); end
    step();
  endtask

  task automatic test_tx_delay();
    logic [7:0] exp;
    logic       pre_bad;
    exp = 8'h5A;
    pre_bad = 1'b0;
    txv = 1'b0; txd = 8'h5A;
    drive_frame(1'b1, 10'h001);
    ss = 1'b1; step();
    drive_frame(1'b1, 10'h302);
    for (int i = 0; i < 5; i++) begin
      step();
      if (miso !== 1'b0) pre_bad = 1'b1;
    end
    n_chk++; if (pre_bad) begin n_fail++; $display("FAIL txdly_wait_miso: got 1 want 0"); end
    txv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      step();
      if (i == 7) begin txv = 1'b0; txd = 8'h00; end
      n_chk++; if (miso !== exp[i]) begin n_fail++; $display("FAIL txdly_bit%0d: got %b want %b", i, miso, exp[i]); end
    end
    step();
    n_chk++; if (miso !== 1'b0) begin n_fail++; $display("FAIL txdly_post: got %b want 0", miso); end
    ss = 1'b1; step();
  endtask

  task automatic test_async_reset();
    logic post_bad;
    post_bad = 1'b0;
    txv = 1'b1; txd = 8'hFF;
    drive_frame(1'b1, 10'h0F0);
    ss = 1'b1; step();
    drive_frame(1'b1, 10'h00F);
    step(); step();
    n_chk++; if (miso !== 1'b1) begin n_fail++; $display("FAIL arst_pre_miso: got %b want 1", miso); end
    #2 rst_n = 1'b0; ss = 1'b1;
    #1;
    n_chk++; if (miso !== 1'b0) begin n_fail++; $display("FAIL arst_miso: got %b want 0", miso); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
    n_chk++; if (rxd !== 10'h000) begin n_fail++; $display("FAIL arst_rxd: got %h want 000", rxd); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (ferr !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_after: got ferr=%b busy=%b want 0/0", ferr, busy); end
    // rd_addr_seen was cleared, so this frame must land as a read address
    drive_frame(1'b1, 10'h155);
    n_chk++; if (rxd !== 10'h155 || rxv !== 1'b1) begin n_fail++; $display("FAIL arst_frame: got %h/%b want 155/1", rxd, rxv); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (miso !== 1'b0) post_bad = 1'b1;
    end
    n_chk++; if (post_bad) begin n_fail++; $display("FAIL arst_readadd: got MISO activity want 0"); end
    ss = 1'b1; txv = 1'b0; step();
  endtask

  task automatic test_lsb_first();
    logic [15:0] exp;
    exp = 16'hB00D;
    txd2 = 16'hB00D; txv2 = 1'b1;
    drive_frame_lsb(1'b1, 16'h8001);
    n_chk++; if (rxd2 !== 16'h8001 || rxv2 !== 1'b1) begin n_fail++; $display("FAIL lsb_addr: got %h/%b want 8001/1", rxd2, rxv2); end
    ss2 = 1'b1; step();
    drive_frame_lsb(1'b1, 16'hC3A5);
    n_chk++; if (rxd2 !== 16'hC3A5) begin n_fail++; $display("FAIL lsb_rxd: got %h want c3a5", rxd2); end
    for (int i = 0; i < 16; i++) begin
      step();
      n_chk++; if (miso2 !== exp[i]) begin n_fail++; $display("FAIL lsb_miso_bit%0d: got %b want %b", i, miso2, exp[i]); end
    end
    step();
    n_chk++; if (miso2 !== 1'b0) begin n_fail++; $display("FAIL lsb_miso_post: got %b want 0", miso2); end
    ss2 = 1'b1; txv2 = 1'b0; step();
    n_chk++; if (busy2 !== 1'b0 || ferr2 !== 1'b0) begin n_fail++; $display("FAIL lsb_idle: got busy=%b ferr=%b want 0/0", busy2, ferr2); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_tx_delay();
    test_async_reset();
    test_lsb_first();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 SHALL have parameter RX_W, default 10: received frame width in bits, including the 2-bit address/data tag; legal range 3..32.
REQ-002 SHALL have parameter TX_W, default 8: read-data width shifted out on MISO; legal range 1..32.
REQ-003 SHALL have parameter LSB_FIRST, default 0: 0 = MSB-first shifting on MOSI and MISO, 1 = LSB-first.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all sampling on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port SS_n, input, 1 bit: active-low slave select.
REQ-007 SHALL have port MOSI, input, 1 bit: serial data in.
REQ-008 SHALL have port tx_data, input, TX_W bits: read data to return.
REQ-009 SHALL have port tx_valid, input, 1 bit: tx_data valid.
REQ-010 SHALL have port MISO, output, 1 bit: serial data out, registered.
REQ-011 SHALL have port rx_data, output, RX_W bits: last complete received frame, registered.
REQ-012 SHALL have port rx_valid, output, 1 bit: one-cycle pulse marking rx_data update.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle pulse on aborted frame.

Function
REQ-015 SHALL implement states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX, DONE.
REQ-016 SHALL move IDLE->CHK_CMD on an edge that samples SS_n=0; otherwise remain in IDLE.
REQ-017 SHALL, in CHK_CMD, sample MOSI as the command bit and branch: 0->WRITE; 1 with rd_addr_seen=0->READ_ADD; 1 with rd_addr_seen=1->READ_DATA.
REQ-018 SHALL, in WRITE/READ_ADD/READ_DATA, shift one MOSI bit per edge into an RX_W-bit shift register, ordered per LSB_FIRST, using a counter of width $clog2(RX_W+1).
REQ-019 SHALL, on the edge sampling bit RX_W, load rx_data from the assembled frame, pulse rx_valid for exactly one cycle, and clear the counter.
REQ-020 SHALL hold rx_data stable between updates; rx_valid otherwise 0.
REQ-021 SHALL, on completion, set rd_addr_seen=1 in READ_ADD and go to DONE; go to DONE from WRITE; go to TX from READ_DATA and clear rd_addr_seen.
REQ-022 SHALL, in TX, wait for tx_valid=1; on that edge capture tx_data and drive its first bit (MSB if LSB_FIRST=0) on MISO.
REQ-023 SHALL drive the remaining TX_W-1 bits on the next TX_W-1 edges, then drive MISO=0 and go to DONE.
REQ-024 SHALL ignore tx_valid and tx_data changes once capture has occurred; MISO=0 in all states except an active TX shift.
REQ-025 SHALL, in DONE, ignore MOSI and return to IDLE on an edge sampling SS_n=1.
REQ-026 SHALL, from CHK_CMD/WRITE/READ_ADD/READ_DATA/TX on an edge sampling SS_n=1, return to IDLE, clear the counter and shift state, force MISO=0, suppress rx_valid, and pulse frame_err; rx_data and rd_addr_seen are retained.
REQ-027 SHALL give SS_n=1 priority over frame completion when both occur on the same edge: frame aborted, no rx_valid.

Reset
REQ-028 SHALL, on rst_n=0 (asynchronous), force state IDLE, MISO=0, rx_data=0, rx_valid=0, busy=0, frame_err=0, counter=0, rd_addr_seen=0, and clear all shift registers.
REQ-029 SHALL resume at IDLE on the first edge after rst_n deasserts; a reset mid-frame SHALL discard that frame without a frame_err pulse.

Verification
REQ-030 SHALL cover write, defaults: SS_n low, MOSI 0 then 10'b00_1010_0101 MSB-first -> rx_data=0x0A5, rx_valid high for one cycle 12 edges after SS_n first sampled low, MISO stays 0.
REQ-031 SHALL cover read address then read data: cmd 1 + 10'b10_0000_0011 -> rd_addr_seen=1; new frame cmd 1 + 10'b11_0000_0000 with tx_data=0xC5, tx_valid=1 -> MISO serial 1,1,0,0,0,1,0,1 on consecutive edges, then 0.
REQ-032 SHALL cover abort: SS_n raised after 5 data bits -> frame_err pulses once, no rx_valid, rx_data unchanged, busy=0 next cycle.
REQ-033 SHALL cover LSB_FIRST=1, RX_W=16, TX_W=16: 16-bit frame and 16-bit readback with bit order reversed versus MSB-first.
REQ-034 SHALL cover async reset: rst_n pulsed low between clock edges during TX -> MISO=0 and busy=0 immediately, rd_addr_seen=0, and the next frame decodes as READ_ADD.
REQ-035 SHALL cover tx_valid delay: tx_valid held low 5 cycles in TX -> MISO=0 until tx_valid=1, then the full TX_W-bit shift.
